// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder and the ALU side.
package data_mem_responder_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/data_mem_array.sv
// Word array with one write port, one registered read port and async clear.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] words [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (we) begin
      words[waddr] <= wdata;
    end
  end

  // rdata only moves on a read, so it keeps the last completed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= words[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Turns the ALU's held load/store levels into single, fixed-latency
// transactions on the internal array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] memory_out,
  output logic [DATA_W-1:0] memory_in,
  output logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, illegal, commit;
  logic              arr_we, arr_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    illegal    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read && mem_write) begin
          illegal    = 1'b1;
          state_next = HOLD;
        end else if (mem_read || mem_write) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      // Waiting for the ALU to drop its level so it cannot re-execute.
      HOLD: begin
        if (!mem_read && !mem_write) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= mem_write ? OP_WRITE : OP_READ;
      addr_q  <= mem_addr;
      wdata_q <= memory_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack  <= 1'b0;
      mem_err  <= 1'b0;
      mem_busy <= 1'b0;
    end else begin
      mem_ack  <= commit;
      mem_err  <= illegal;
      mem_busy <= (state_next != IDLE);
    end
  end

  assign arr_we = commit && (op_q == OP_WRITE);
  assign arr_re = commit && (op_q == OP_READ);

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (arr_re),
    .raddr (addr_q),
    .rdata (memory_in)
  );

endmodule
